// File: rtl/ram4k9_pkg.sv
// ============================================================================
// Module  : ram4k9_pkg
// Brief   : Shared types and constants for the RAM4K9 port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ram4k9_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 9;

    // WIDTHx1/WIDTHx0 codes for the RAM4K9 aspect ratios
    localparam logic [1:0] WIDTH_4096X1 = 2'b00;
    localparam logic [1:0] WIDTH_2048X2 = 2'b01;
    localparam logic [1:0] WIDTH_1024X4 = 2'b10;
    localparam logic [1:0] WIDTH_512X9  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram4k9_port_arbiter_rr_arb2.sv
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-way round-robin pick with request mask and last-grant pointer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_i,
    input  logic [1:0] mask_i,
    input  logic       take_i,
    output logic       valid_o,
    output logic       idx_o
);

    logic       last_q;
    logic [1:0] elig;

    assign elig = req_i & ~mask_i;

    // On a tie the requester not served last wins
    always_comb begin
        valid_o = |elig;
        idx_o   = (elig == 2'b11) ? ~last_q : elig[1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (take_i && valid_o) begin
            last_q <= idx_o;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram4k9_port_arbiter.sv
// ============================================================================
// Module  : ram4k9_port_arbiter
// Brief   : Round-robin sharing of one RAM4K9 port (512x9) between two
//           requesters. Build macro RAM4K9_PIPE_EN enables the RAM output
//           register and the extra read wait cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram4k9_port_arbiter
    import ram4k9_pkg::*;
#(
    parameter int         ADDR_W     = ADDR_W_DEF,
    parameter int         DATA_W     = DATA_W_DEF,
    parameter logic [1:0] WIDTH_CODE = WIDTH_512X9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] din0,
    output logic              ack0,
    output logic [DATA_W-1:0] dout0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] din1,
    output logic              ack1,
    output logic [DATA_W-1:0] dout1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              ram_blk,
    output logic              ram_wen,
    output logic [1:0]        ram_width,
    output logic              ram_pipe,
    output logic              ram_wmode,
    output logic              grant
);

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_din_q, ram_din_d;
    logic                ram_blk_q, ram_blk_d;
    logic                ram_wen_q, ram_wen_d;
    logic [1:0]          ack_q, ack_d;
    logic [DATA_W-1:0]   dout0_q, dout0_d;
    logic [DATA_W-1:0]   dout1_q, dout1_d;

    logic [1:0]          arb_mask;
    logic                arb_take;
    logic                arb_valid;
    logic                arb_idx;

    // The requester acked in DONE is masked so the other side gets the port
    assign arb_mask = (state_q == ST_DONE) ? onehot2(grant_q) : 2'b00;
    assign arb_take = arb_valid && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset_n (reset_n),
        .req_i   ({req1, req0}),
        .mask_i  (arb_mask),
        .take_i  (arb_take),
        .valid_o (arb_valid),
        .idx_o   (arb_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (arb_valid) state_d = ST_ACCESS;
`ifdef RAM4K9_PIPE_EN
            ST_ACCESS: state_d = we_q ? ST_DONE : ST_WAIT;
`else
            ST_ACCESS: state_d = ST_DONE;
`endif
            ST_WAIT:   state_d = ST_DONE;
            ST_DONE:   state_d = arb_valid ? ST_ACCESS : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_d    = grant_q;
        we_d       = we_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_blk_d  = 1'b1;
        ram_wen_d  = 1'b1;
        ack_d      = 2'b00;
        dout0_d    = dout0_q;
        dout1_d    = dout1_q;

        if (arb_take) begin
            grant_d    = arb_idx;
            we_d       = arb_idx ? we1   : we0;
            ram_addr_d = arb_idx ? addr1 : addr0;
            ram_din_d  = arb_idx ? din1  : din0;
            ram_blk_d  = 1'b0;
            ram_wen_d  = arb_idx ? ~we1  : ~we0;
        end

        if (((state_q == ST_ACCESS) || (state_q == ST_WAIT)) && (state_d == ST_DONE)) begin
            ack_d[grant_q] = 1'b1;
        end

        if ((state_q == ST_DONE) && !we_q) begin
            if (grant_q) dout1_d = ram_dout;
            else         dout0_d = ram_dout;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q    <= 1'b0;
            we_q       <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_blk_q  <= 1'b1;
            ram_wen_q  <= 1'b1;
            ack_q      <= 2'b00;
            dout0_q    <= '0;
            dout1_q    <= '0;
        end else begin
            grant_q    <= grant_d;
            we_q       <= we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_blk_q  <= ram_blk_d;
            ram_wen_q  <= ram_wen_d;
            ack_q      <= ack_d;
            dout0_q    <= dout0_d;
            dout1_q    <= dout1_d;
        end
    end

    // Read data is forwarded straight from the RAM during the ack cycle
    assign dout0 = (ack_q[0] && !we_q) ? ram_dout : dout0_q;
    assign dout1 = (ack_q[1] && !we_q) ? ram_dout : dout1_q;
    assign ack0  = ack_q[0];
    assign ack1  = ack_q[1];

    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign ram_blk   = ram_blk_q;
    assign ram_wen   = ram_wen_q;
    assign ram_width = WIDTH_CODE;
    assign ram_wmode = 1'b0;
    assign grant     = grant_q;
`ifdef RAM4K9_PIPE_EN
    assign ram_pipe  = 1'b1;
`else
    assign ram_pipe  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram4k9_port_arbiter.sv
// ============================================================================
// Module  : tb_ram4k9_port_arbiter
// Brief   : Directed self-checking bench with a behavioural RAM4K9 model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram4k9_port_arbiter;

`ifdef RAM4K9_PIPE_EN
    localparam int   RD_LAT   = 3;
    localparam logic EXP_PIPE = 1'b1;
`else
    localparam int   RD_LAT   = 2;
    localparam logic EXP_PIPE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req0, we0, req1, we1;
    logic [8:0] addr0, din0, addr1, din1;
    logic       ack0, ack1;
    logic [8:0] dout0, dout1;
    logic [8:0] ram_addr, ram_din, ram_dout;
    logic       ram_blk, ram_wen, ram_pipe, ram_wmode, grant;
    logic [1:0] ram_width;

    logic       preload;
    logic [8:0] mem [512];
    logic [8:0] rd_q, pipe_q;

    int n_checks;
    int n_fail;
    logic exp_g;

    always #5 clk = ~clk;

    ram4k9_port_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .din0      (din0),
        .ack0      (ack0),
        .dout0     (dout0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .din1      (din1),
        .ack1      (ack1),
        .dout1     (dout1),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .ram_blk   (ram_blk),
        .ram_wen   (ram_wen),
        .ram_width (ram_width),
        .ram_pipe  (ram_pipe),
        .ram_wmode (ram_wmode),
        .grant     (grant)
    );

    // RAM4K9 port model: samples on the clock edge, WMODE=0, optional output register
    always @(posedge clk) begin
        if (preload) begin
            mem[9'h010] <= 9'h0C3;
        end else if (!ram_blk) begin
            if (!ram_wen) mem[ram_addr] <= ram_din;
            else          rd_q <= mem[ram_addr];
        end
        pipe_q <= rd_q;
    end
    assign ram_dout = EXP_PIPE ? pipe_q : rd_q;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b1;
        preload  = 1'b1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 9'h03F; din0 = 9'h1A5;
        req1 = 1'b0; we1 = 1'b0; addr1 = 9'h000; din1 = 9'h000;
        #1 reset_n = 1'b0;

        // Reset held with a pending request
        repeat (3) begin
            step();
            chk("rst_blk", ram_blk, 1);
            chk("rst_wen", ram_wen, 1);
            chk("rst_ack0", ack0, 0);
        end
        chk("rst_grant", grant, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_din", ram_din, 0);
        chk("rst_dout0", dout0, 0);
        chk("rst_width", ram_width, 2'b11);
        chk("rst_wmode", ram_wmode, 0);
        chk("rst_pipe", ram_pipe, EXP_PIPE);
        preload = 1'b0;
        reset_n = 1'b1;

        // Write 1A5 to 03F
        step();
        chk("wr_blk", ram_blk, 0);
        chk("wr_wen", ram_wen, 0);
        chk("wr_addr", ram_addr, 9'h03F);
        chk("wr_din", ram_din, 9'h1A5);
        chk("wr_grant", grant, 0);
        chk("wr_ack0_early", ack0, 0);
        step();
        chk("wr_ack0", ack0, 1);
        chk("wr_wen_one_cycle", ram_wen, 1);
        chk("wr_blk_off", ram_blk, 1);
        chk("wr_ack1", ack1, 0);
        req0 = 1'b0;
        step();
        chk("wr_ack0_pulse", ack0, 0);

        // Read back 03F
        req0 = 1'b1; we0 = 1'b0;
        step();
        chk("rd_blk", ram_blk, 0);
        chk("rd_wen", ram_wen, 1);
        chk("rd_addr", ram_addr, 9'h03F);
        repeat (RD_LAT - 2) begin
            step();
            chk("rd_ack0_wait", ack0, 0);
        end
        step();
        chk("rd_ack0", ack0, 1);
        chk("rd_dout0", dout0, 9'h1A5);
        req0 = 1'b0;
        step();
        chk("rd_ack0_pulse", ack0, 0);
        chk("rd_dout0_hold", dout0, 9'h1A5);

        // Requester 1 reads the preloaded word
        req1 = 1'b1; we1 = 1'b0; addr1 = 9'h010;
        step();
        chk("pre_grant", grant, 1);
        chk("pre_blk", ram_blk, 0);
        repeat (RD_LAT - 2) begin
            step();
            chk("pre_ack1_wait", ack1, 0);
        end
        step();
        chk("pre_ack1", ack1, 1);
        chk("pre_ack0", ack0, 0);
        chk("pre_dout1", dout1, 9'h0C3);
        req1 = 1'b0;
        step();

        // Contention: both read continuously, grants alternate starting with 0
        req0 = 1'b1; we0 = 1'b0; addr0 = 9'h03F;
        req1 = 1'b1; we1 = 1'b0; addr1 = 9'h010;
        for (int k = 0; k < 4; k++) begin
            exp_g = 1'(k % 2);
            step();
            chk("cont_grant", grant, exp_g);
            chk("cont_blk", ram_blk, 0);
            chk("cont_noack", {ack1, ack0}, 2'b00);
            repeat (RD_LAT - 2) begin
                step();
                chk("cont_noack_wait", {ack1, ack0}, 2'b00);
            end
            step();
            chk("cont_ack0", ack0, !exp_g);
            chk("cont_ack1", ack1, exp_g);
            chk("cont_dout", exp_g ? dout1 : dout0, exp_g ? 9'h0C3 : 9'h1A5);
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        chk("cont_idle", {ack1, ack0, ram_blk}, 3'b001);

        // Handoff: req1 rises during requester 0's ACCESS
        req0 = 1'b1; we0 = 1'b1; addr0 = 9'h020; din0 = 9'h155;
        step();
        chk("ho_wen0", ram_wen, 0);
        req1 = 1'b1; we1 = 1'b0; addr1 = 9'h03F;
        step();
        chk("ho_ack0", ack0, 1);
        chk("ho_dout0_hold", dout0, 9'h1A5);
        req0 = 1'b0;
        step();
        chk("ho_direct_blk", ram_blk, 0);
        chk("ho_grant", grant, 1);
        chk("ho_addr", ram_addr, 9'h03F);
        chk("ho_ack0_off", ack0, 0);
        repeat (RD_LAT - 2) begin
            step();
            chk("ho_ack1_wait", ack1, 0);
        end
        step();
        chk("ho_ack1", ack1, 1);
        chk("ho_dout1", dout1, 9'h1A5);
        req1 = 1'b0;
        step();

        // Reset pulse in the middle of a read access
        req1 = 1'b1; we1 = 1'b0; addr1 = 9'h020;
        step();
        chk("mr_blk_pre", ram_blk, 0);
        chk("mr_grant_pre", grant, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("mr_blk", ram_blk, 1);
        chk("mr_wen", ram_wen, 1);
        chk("mr_addr", ram_addr, 0);
        chk("mr_grant", grant, 0);
        chk("mr_dout1", dout1, 0);
        req1 = 1'b0;
        step();
        chk("mr_ack1", ack1, 0);
        reset_n = 1'b1;
        step();
        chk("mr_noack", {ack1, ack0}, 2'b00);

        // Service resumes: read back the word written during handoff
        req0 = 1'b1; we0 = 1'b0; addr0 = 9'h020;
        step();
        chk("post_blk", ram_blk, 0);
        chk("post_addr", ram_addr, 9'h020);
        repeat (RD_LAT - 2) begin
            step();
            chk("post_ack0_wait", ack0, 0);
        end
        step();
        chk("post_ack0", ack0, 1);
        chk("post_dout0", dout0, 9'h155);
        req0 = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
